// File: rtl/ahb_cmd_master.sv
// ---------------------------------------------------------------------------
// ahb_cmd_master
// AHB-Lite single-transfer master that turns a valid/ready command stream into
// pipelined AHB address/data phases and returns one in-order response per
// command. Handles wait states, the two-cycle ERROR response (with retry of
// the command sitting in the address phase) and misaligned commands, which are
// never put on the bus but still produce an error response in order.
//
// Optional build macro: AHB_CMD_MASTER_LANE_ALIGN_EN
//   defined   : write data is right-justified and shifted into lanes by
//               addr[1:0]; read data is shifted down by the captured addr[1:0]
//               and zero-extended to the transfer size.
//   undefined : data passes through unmodified in both directions.
//
// Ports
//   hclk, hresetn          clock, async active-low reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready is combinational)
//   cmd_write/addr/size/wdata  command fields (size in AHB hsize encoding)
//   rsp_valid/rdata/err    one-cycle response pulse per completed command
//   haddr/htrans/hwrite/hsize/hburst/hwdata   AHB master outputs (registered)
//   hready/hresp/hrdata    AHB slave returns
//
// Error FSM
//   state     | meaning
//   ST_NORMAL | pipeline advances on every hready=1 edge
//   ST_ERR2   | second ERROR cycle: bus IDLE, address phase held for retry
// ---------------------------------------------------------------------------
module ahb_cmd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic [1:0]        hresp,
  input  logic [DATA_W-1:0] hrdata
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic {ST_NORMAL, ST_ERR2} err_state_t;

  err_state_t        r_state;

  // address-phase slot
  logic              r_ap_valid;
  logic              r_ap_fault;
  logic              r_ap_write;
  logic [ADDR_W-1:0] r_ap_addr;
  logic [2:0]        r_ap_size;
  logic [DATA_W-1:0] r_ap_wdata;

  // data-phase slot; r_hwdata doubles as the data-phase write data
  logic              r_dp_valid;
  logic              r_dp_fault;
  logic              r_dp_write;
  logic [DATA_W-1:0] r_hwdata;

  logic [1:0]        r_htrans;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_cmd_fault;
  logic              w_accept;
  logic              w_hresp_err;
  logic              w_dp_err;
  logic [DATA_W-1:0] w_ap_wdata_in;
  logic [DATA_W-1:0] w_rd_data;

  assign w_cmd_fault = (cmd_size > 3'd2) |
                       ((cmd_size == 3'd1) & cmd_addr[0]) |
                       ((cmd_size == 3'd2) & (cmd_addr[1:0] != 2'b00));
  assign cmd_ready   = hready & (r_state == ST_NORMAL) & hresetn;
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_hresp_err = (hresp == 2'b01);
  assign w_dp_err    = r_dp_fault | w_hresp_err;

`ifdef AHB_CMD_MASTER_LANE_ALIGN_EN
  logic [1:0]        r_dp_lane;
  logic [2:0]        r_dp_size;
  logic [DATA_W-1:0] w_rd_shift;

  assign w_ap_wdata_in = cmd_wdata << {cmd_addr[1:0], 3'b000};

  always_comb begin
    w_rd_shift = hrdata >> {r_dp_lane, 3'b000};
    case (r_dp_size)
      3'd0:    w_rd_data = {{(DATA_W-8){1'b0}},  w_rd_shift[7:0]};
      3'd1:    w_rd_data = {{(DATA_W-16){1'b0}}, w_rd_shift[15:0]};
      default: w_rd_data = w_rd_shift;
    endcase
  end
`else
  assign w_ap_wdata_in = cmd_wdata;
  assign w_rd_data     = hrdata;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= ST_NORMAL;
      r_ap_valid  <= 1'b0;
      r_ap_fault  <= 1'b0;
      r_ap_write  <= 1'b0;
      r_ap_addr   <= '0;
      r_ap_size   <= 3'd0;
      r_ap_wdata  <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_fault  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_hwdata    <= '0;
      r_htrans    <= TRANS_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef AHB_CMD_MASTER_LANE_ALIGN_EN
      r_dp_lane   <= 2'b00;
      r_dp_size   <= 3'd0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_NORMAL: begin
          if (hready) begin
            if (r_dp_valid) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_dp_err;
              r_rsp_rdata <= (!r_dp_write && !w_dp_err) ? w_rd_data : '0;
            end
            r_dp_valid <= r_ap_valid;
            r_dp_fault <= r_ap_fault;
            r_dp_write <= r_ap_write;
            if (r_ap_valid && r_ap_write)
              r_hwdata <= r_ap_wdata;
`ifdef AHB_CMD_MASTER_LANE_ALIGN_EN
            r_dp_lane  <= r_ap_addr[1:0];
            r_dp_size  <= r_ap_size;
`endif
            r_ap_valid <= w_accept;
            if (w_accept) begin
              r_ap_fault <= w_cmd_fault;
              r_ap_write <= cmd_write;
              r_ap_addr  <= cmd_addr;
              r_ap_size  <= cmd_size;
              r_ap_wdata <= w_ap_wdata_in;
            end
            r_htrans <= (w_accept && !w_cmd_fault) ? TRANS_NONSEQ : TRANS_IDLE;
          end else if (r_dp_valid && w_hresp_err) begin
            // first ERROR cycle: pull the pending address phase off the bus
            // but keep it in the slot so it can be retried
            r_htrans <= TRANS_IDLE;
            r_state  <= ST_ERR2;
          end
        end
        ST_ERR2: begin
          if (hready) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_dp_valid  <= 1'b0;
            r_htrans    <= (r_ap_valid && !r_ap_fault) ? TRANS_NONSEQ : TRANS_IDLE;
            r_state     <= ST_NORMAL;
          end
        end
      endcase
    end
  end

  assign haddr     = r_ap_addr;
  assign hwrite    = r_ap_write;
  assign hsize     = r_ap_size;
  assign htrans    = r_htrans;
  assign hburst    = 3'b000;
  assign hwdata    = r_hwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// ---------------------------------------------------------------------------
// Bench for ahb_cmd_master (default build). A small AHB slave with wait-state
// and ERROR injection sits on the bus; a byte-addressed reference memory
// executes each command in issue order and queues the response it must
// produce. A negedge monitor compares every rsp_valid pulse against that
// queue and checks bus behaviour during waits and errors.
// ---------------------------------------------------------------------------
module tb_ahb_cmd_master;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_size = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  always #5 hclk = ~hclk;

  ahb_cmd_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  // ---------------- AHB slave ----------------
  logic [31:0] smem [64];
  logic        mem_inited = 1'b0;
  logic        s_act, s_write, s_err, s_errcyc;
  logic [31:0] s_addr;
  logic [2:0]  s_size;
  int          s_wait;
  bit          err_en = 0;
  logic [31:0] err_addr = '0;
  bit          wait_en = 0;
  logic [31:0] wait_addr = '0;
  int          wait_n = 0;

  always_comb begin
    hready = !s_act ? 1'b1 : (s_err ? s_errcyc : (s_wait == 0));
    hresp  = (s_act && s_err) ? 2'b01 : 2'b00;
    hrdata = smem[s_addr[7:2]];
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] lo, input logic [2:0] sz);
    logic [31:0] m;
    case (sz)
      3'd0:    m = 32'h0000_00ff << (8 * lo);
      3'd1:    m = 32'h0000_ffff << (8 * lo);
      default: m = 32'hffff_ffff;
    endcase
    return (old & ~m) | (wd & m);
  endfunction

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      s_act <= 1'b0; s_write <= 1'b0; s_err <= 1'b0; s_errcyc <= 1'b0;
      s_addr <= '0; s_size <= '0; s_wait <= 0;
      if (!mem_inited) begin
        for (int i = 0; i < 64; i++) smem[i] <= 32'hA500_0000 | i;
        mem_inited <= 1'b1;
      end
    end else begin
      if (s_act && hready) begin
        if (s_write && !s_err)
          smem[s_addr[7:2]] <= merge(smem[s_addr[7:2]], hwdata, s_addr[1:0], s_size);
        s_act <= 1'b0;
      end else if (s_act) begin
        if (s_err) s_errcyc <= 1'b1;
        else       s_wait   <= s_wait - 1;
      end
      if (hready && htrans == 2'b10) begin
        s_act    <= 1'b1;
        s_addr   <= haddr;
        s_write  <= hwrite;
        s_size   <= hsize;
        s_err    <= err_en && (haddr == err_addr);
        s_errcyc <= 1'b0;
        s_wait   <= (wait_en && haddr == wait_addr) ? wait_n : 0;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct { logic err; logic [31:0] rdata; } exp_t;
  exp_t        q[$];
  logic [7:0]  mb [256];

  task automatic model_exec(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata);
    exp_t e;
    logic [7:0] a;
    logic [7:0] base;
    bit bad;
    bad = (size > 2) || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00);
    e.err = 1'b0; e.rdata = '0;
    if (bad || (err_en && addr == err_addr)) begin
      e.err = 1'b1;
    end else if (wr) begin
      for (int k = 0; k < (1 << size); k++) begin
        a = addr[7:0] + 8'(k);
        mb[a] = wdata[8 * a[1:0] +: 8];
      end
    end else begin
      base = {addr[7:2], 2'b00};
      e.rdata = {mb[base + 8'd3], mb[base + 8'd2], mb[base + 8'd1], mb[base]};
    end
    q.push_back(e);
  endtask

  // ---------------- monitor / compare ----------------
  int          rsp_cnt = 0;
  int          rsp_cyc_log[$];
  logic [31:0] rsp_data_log[$];
  logic        rsp_err_log[$];
  int          nonseq_run = 0, max_run = 0, nonseq_misaligned = 0;
  bit          prev_wait = 0, post_err = 0;
  logic [31:0] p_haddr, p_hwdata;
  logic [1:0]  p_htrans;
  logic        p_hwrite;
  logic [1:0]  after_err_htrans = '0;
  logic [31:0] after_err_haddr = '0;
  exp_t        e_m;

  always @(negedge hclk) begin
    if (hresetn) begin
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cyc_log.push_back(cyc);
        rsp_data_log.push_back(rsp_rdata);
        rsp_err_log.push_back(rsp_err);
        if (q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e_m = q.pop_front();
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e_m.err});
          check("rsp_rdata", rsp_rdata, e_m.rdata);
        end
      end
      if (htrans == 2'b10) nonseq_run++; else nonseq_run = 0;
      if (nonseq_run > max_run) max_run = nonseq_run;
      if (htrans == 2'b10 && haddr == 32'h2) nonseq_misaligned++;
      if (prev_wait) begin
        check("wait_haddr_stable", haddr, p_haddr);
        check("wait_htrans_stable", {30'b0, htrans}, {30'b0, p_htrans});
        check("wait_hwdata_stable", hwdata, p_hwdata);
        check("wait_hwrite_stable", {31'b0, hwrite}, {31'b0, p_hwrite});
      end
      if (!hready && hresp == 2'b00) check("wait_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      if (hready && hresp == 2'b01) begin
        check("err2_htrans_idle", {30'b0, htrans}, 32'd0);
        check("err2_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        post_err = 1;
      end else if (post_err) begin
        post_err = 0;
        after_err_htrans = htrans;
        after_err_haddr  = haddr;
      end
      prev_wait = !hready && hresp == 2'b00;
      p_haddr = haddr; p_htrans = htrans; p_hwdata = hwdata; p_hwrite = hwrite;
    end else begin
      prev_wait = 0;
      post_err  = 0;
      check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic send(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output int t_issue);
    int b = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
    while (!cmd_ready && b < 50) begin @(negedge hclk); #1; b++; end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      t_issue = -1;
      return;
    end
    t_issue = cyc;
    model_exec(wr, addr, size, wdata);
    @(negedge hclk); #1;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int b = 0;
    while (rsp_cnt < target && b < 100) begin @(negedge hclk); #1; b++; end
    if (rsp_cnt < target) check("rsp_timeout", rsp_cnt, target);
  endtask

  // ---------------- directed sequence ----------------
  int t, t_rd, base;

  initial begin
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 4; k++) begin
        logic [31:0] w;
        w = 32'hA500_0000 | i;
        mb[i * 4 + k] = w[8 * k +: 8];
      end

    repeat (3) @(negedge hclk);
    check("rst_htrans", {30'b0, htrans}, 32'd0);
    check("rst_haddr", haddr, 32'd0);
    check("rst_hwrite", {31'b0, hwrite}, 32'd0);
    check("rst_hsize", {29'b0, hsize}, 32'd0);
    check("rst_hburst", {29'b0, hburst}, 32'd0);
    check("rst_hwdata", hwdata, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    #1 hresetn = 1'b1;
    @(negedge hclk); #1;

    // write word then read back
    send(1, 32'hffff_fffc, 3'd2, 32'h2021_1212, t);
    send(0, 32'hffff_fffc, 3'd2, 32'h0, t_rd);
    idle();
    wait_rsp(2);
    check("wr_rd_rdata", rsp_data_log[1], 32'h2021_1212);
    check("wr_rd_err", {31'b0, rsp_err_log[1]}, 32'd0);
    check("rd_latency", rsp_cyc_log[1] - t_rd, 32'd3);
    repeat (2) @(negedge hclk); #1;

    // back-to-back half, byte, word read
    max_run = 0;
    base = rsp_cnt;
    send(1, 32'hffff_fffe, 3'd1, 32'habcd_0000, t);
    send(1, 32'hffff_ffff, 3'd0, 32'h5900_0000, t);
    send(0, 32'hffff_fffc, 3'd2, 32'h0, t_rd);
    idle();
    wait_rsp(base + 3);
    check("b2b_nonseq_run", max_run, 32'd3);
    check("b2b_rdata", rsp_data_log[base + 2], 32'h59cd_1212);
    check("b2b_cycles", rsp_cyc_log[base + 2] - rsp_cyc_log[base], 32'd2);
    repeat (2) @(negedge hclk); #1;

    // two wait states on read of 0x10, a write waiting in the address phase
    wait_en = 1; wait_addr = 32'h10; wait_n = 2;
    base = rsp_cnt;
    send(0, 32'h0000_0010, 3'd2, 32'h0, t_rd);
    send(1, 32'h0000_0014, 3'd2, 32'hcafe_f00d, t);
    idle();
    wait_rsp(base + 2);
    wait_en = 0;
    check("wait_latency", rsp_cyc_log[base] - t_rd, 32'd5);
    check("wait_rdata", rsp_data_log[base], 32'hA500_0004);
    repeat (2) @(negedge hclk); #1;

    // ERROR on write to 0x20 with read of 0x24 in the address phase
    err_en = 1; err_addr = 32'h20;
    base = rsp_cnt;
    send(1, 32'h0000_0020, 3'd2, 32'h1111_1111, t);
    send(0, 32'h0000_0024, 3'd2, 32'h0, t);
    idle();
    wait_rsp(base + 2);
    err_en = 0;
    check("err_first_err", {31'b0, rsp_err_log[base]}, 32'd1);
    check("err_second_ok", {31'b0, rsp_err_log[base + 1]}, 32'd0);
    check("err_retry_rdata", rsp_data_log[base + 1], 32'hA500_0009);
    check("err_retry_htrans", {30'b0, after_err_htrans}, 32'd2);
    check("err_retry_haddr", after_err_haddr, 32'h24);
    repeat (2) @(negedge hclk); #1;

    // misaligned/illegal commands between valid reads
    nonseq_misaligned = 0;
    base = rsp_cnt;
    send(0, 32'h0000_0010, 3'd2, 32'h0, t);
    send(0, 32'h0000_0002, 3'd2, 32'h0, t);
    send(0, 32'h0000_0020, 3'd2, 32'h0, t);
    send(1, 32'h0000_0013, 3'd1, 32'h0, t);
    send(0, 32'h0000_0000, 3'd3, 32'h0, t);
    send(0, 32'h0000_0013, 3'd0, 32'h0, t);
    idle();
    wait_rsp(base + 6);
    check("mis_no_bus", nonseq_misaligned, 32'd0);
    check("mis_first_ok", {31'b0, rsp_err_log[base]}, 32'd0);
    check("mis_mid_err", {31'b0, rsp_err_log[base + 1]}, 32'd1);
    check("mis_mid_rdata", rsp_data_log[base + 1], 32'd0);
    check("mis_last_rdata", rsp_data_log[base + 2], 32'hA500_0008);
    check("mis_half_err", {31'b0, rsp_err_log[base + 3]}, 32'd1);
    check("mis_size3_err", {31'b0, rsp_err_log[base + 4]}, 32'd1);
    check("byte_odd_ok", {31'b0, rsp_err_log[base + 5]}, 32'd0);
    repeat (2) @(negedge hclk); #1;

    // reset in the middle of a read
    base = rsp_cnt;
    send(0, 32'h0000_0014, 3'd2, 32'h0, t);
    idle();
    @(posedge hclk); #2;
    hresetn = 1'b0;
    q.delete();
    #1;
    check("mid_rst_htrans", {30'b0, htrans}, 32'd0);
    check("mid_rst_haddr", haddr, 32'd0);
    check("mid_rst_hwdata", hwdata, 32'd0);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    repeat (2) @(negedge hclk);
    #1 hresetn = 1'b1;
    repeat (3) @(negedge hclk); #1;
    check("mid_rst_no_rsp", rsp_cnt, base);
    send(1, 32'h0000_0030, 3'd2, 32'h1234_5678, t);
    send(0, 32'h0000_0030, 3'd2, 32'h0, t_rd);
    idle();
    wait_rsp(base + 2);
    check("post_rst_rdata", rsp_data_log[base + 1], 32'h1234_5678);
    check("post_rst_latency", rsp_cyc_log[base + 1] - t_rd, 32'd3);
    repeat (3) @(negedge hclk); #1;

    check("all_rsp_received", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_cmd_master.md
Name: ahb_cmd_master

Overview:
AHB-Lite single-transfer master that sits directly upstream of the AHB-to-SRAM controller (sram_ctr_ahb) and drives its hclk-domain AHB slave port. It converts a simple valid/ready command stream (write/read, address, size, data) into pipelined AHB address and data phases. It returns one in-order response per command (read data plus error flag). Wait states, the two-cycle ERROR response and misaligned commands are handled without dropping or reordering commands.

Parameters:
ADDR_W, 32, width of cmd_addr and haddr
DATA_W, 32, width of data buses (fixed at 32 for byte-lane logic)

Ports:
hclk  in  1  AHB clock, rising edge
hresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted on edge where cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_size  in  3  AHB hsize encoding (0=byte, 1=half, 2=word)
cmd_wdata  in  DATA_W  write data, already in AHB byte lanes
rsp_valid  out  1  one-cycle pulse per completed command
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  1=ERROR response or misaligned/illegal command
haddr  out  ADDR_W  AHB address
htrans  out  2  IDLE=00 or NONSEQ=10 only
hwrite  out  1  AHB write
hsize  out  3  AHB size
hburst  out  3  constant 000 (SINGLE)
hwdata  out  DATA_W  write data during data phase
hready  in  1  transfer done / bus ready
hresp  in  2  00=OKAY, 01=ERROR
hrdata  in  DATA_W  read data

Behaviour:
- Two internal slots: AP (address phase: valid, fault, write, addr, size, wdata) and DP (data phase: valid, fault, write, wdata).
- Reset (async, hresetn=0): htrans=00, haddr=0, hwrite=0, hsize=000, hburst=000, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; AP/DP empty; error FSM in NORMAL. Reset mid-transfer discards all in-flight commands with no response.
- cmd_ready = hready & (err_state==NORMAL) & hresetn. This is the only combinational output.
- On each edge with hready=1 in NORMAL: DP<=AP; AP<=accepted command, else empty.
- AP outputs are registered: haddr/hwrite/hsize take AP fields. htrans=NONSEQ if AP valid & !fault, else IDLE. Commands appear on the bus the cycle after acceptance.
- hwdata = DP.wdata while DP valid & write, else holds its last value.
- Misaligned/illegal commands set fault and are driven as IDLE:
  - cmd_size>2,
  - size=1 with addr[0]=1,
  - size=2 with addr[1:0]!=0.
  - Faulted commands still traverse AP->DP so responses stay in order.
- DP completion on an edge with hready=1:
  - rsp_valid=1 next cycle.
  - rsp_err = fault | (hresp==01).
  - rsp_rdata = hrdata if read & !err, else 0.
  - rsp_valid stays low on every other cycle. No response backpressure.
- Error FSM, states NORMAL, ERR2:
  - NORMAL: DP valid, hready=0, hresp=01 (first ERROR cycle). At that edge drive htrans=IDLE (AP cancelled on bus, retained internally) and go to ERR2.
  - ERR2: at the hready=1 edge, DP completes with rsp_err=1, DP empty. AP is re-driven as NONSEQ (retry) without advancing, and the FSM returns to NORMAL.
  - cmd_ready=0 in ERR2 and in the first ERROR cycle.
- Wait states (hready=0, hresp=OKAY): all outputs and slots hold unchanged.
- Throughput: back-to-back zero-wait commands complete one per cycle. Read latency from acceptance to rsp_valid is 3 cycles at zero wait.

Optional Feature:
Macro AHB_CMD_MASTER_LANE_ALIGN_EN.
- Defined:
  - Writes: cmd_wdata is right-justified and is shifted into lanes by addr[1:0] (×8 bits) before storing.
  - Reads: rsp_rdata is hrdata shifted right by the captured addr[1:0] and zero-extended to the transfer size.
- Undefined: data passes unmodified in both directions; no addr[1:0] is kept in DP.

Test Plan:
- Reset → htrans=00, rsp_valid=0. Then write word 0xfffffffc/0x20211212 and read it back → rsp_rdata=0x20211212, rsp_err=0, read latency 3 cycles.
- Back-to-back writes of half 0xfffffffe/0xabcd0000 and byte 0xffffffff/0x59000000, then word read 0xfffffffc → htrans NONSEQ on consecutive cycles, read returns 0x59cd1212.
- Slave inserts 2 wait states on a read of 0x00000010 (hready=0 twice) → haddr/htrans/hwdata stable, cmd_ready=0, rsp_valid 2 cycles later than zero-wait.
- ERROR response on the write to 0x00000020 while a read of 0x24 is in AP:
  - htrans=00 in the second error cycle, then 0x24 re-issued as NONSEQ.
  - Responses in order: err=1, then err=0.
- Misaligned word at 0x00000002 sandwiched between two valid reads → bus sees IDLE for it, three in-order responses with middle rsp_err=1.
- hresetn low mid-read → all outputs at reset values immediately, no rsp_valid, next command after release completes normally.
